// File: rtl/shift_unit.sv
// shift_unit: multi-cycle SHR/SHRA/SHL/ROR/ROL on a WIDTH-bit operand, at most STEP positions per clock.
// Latency: ceil(eff/STEP)+1 cycles from accepted start to the one-cycle done pulse (eff=0/illegal: 1 cycle).
// Backpressure: start is sampled only while idle; any start seen while busy (incl. the done cycle) is dropped.
// Optional feature macro: SHIFT_UNIT_ROTATE_EN enables ROR/ROL; without it those opcodes report illegal.

module shift_unit #(
  parameter  int WIDTH   = 32,
  parameter  int STEP    = 4,
  localparam int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] amount,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
`endif

  // Saturation limit for plain shifts and the per-cycle step, both in amount units.
  localparam logic [SHAMT_W-1:0] WIDTH_AMT = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] STEP_AMT  = SHAMT_W'(STEP);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               sign_q, sign_d;
  logic               ill_q, ill_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               op_illegal;
  logic [SHAMT_W-1:0] eff_amt;
  logic [SHAMT_W-1:0] step_k;
  logic [WIDTH-1:0]   fill_mask;
  logic [WIDTH-1:0]   step_result;

  // Classify the incoming opcode; rotates count as legal only when the rotate option is built in.
  always_comb begin
    op_illegal = 1'b1;
    case (op)
      OP_SHR, OP_SHRA, OP_SHL: op_illegal = 1'b0;
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROR, OP_ROL:          op_illegal = 1'b0;
`endif
      default:                 op_illegal = 1'b1;
    endcase
  end

  // Effective amount: plain shifts saturate at WIDTH, rotates wrap modulo WIDTH, illegal ops do nothing.
  always_comb begin
    eff_amt = (amount > WIDTH_AMT) ? WIDTH_AMT : amount;
`ifdef SHIFT_UNIT_ROTATE_EN
    if (op == OP_ROR || op == OP_ROL) begin
      eff_amt = {1'b0, amount[SHAMT_W-2:0]};
    end
`endif
    if (op_illegal) begin
      eff_amt = '0;
    end
  end

  // One step of the iterative shift: move min(STEP, rem) positions with the op's fill rule.
  always_comb begin
    step_k      = (rem_q > STEP_AMT) ? STEP_AMT : rem_q;
    // Top step_k bits set; used to back-fill the latched sign on arithmetic shifts.
    fill_mask   = ~({WIDTH{1'b1}} >> step_k);
    step_result = result_q;
    case (op_q)
      OP_SHR:  step_result = result_q >> step_k;
      OP_SHRA: step_result = (result_q >> step_k) | (sign_q ? fill_mask : '0);
      OP_SHL:  step_result = result_q << step_k;
`ifdef SHIFT_UNIT_ROTATE_EN
      // Rotate step_k is 1..WIDTH-1 while shifting, so the complementary shift never hits WIDTH.
      OP_ROR:  step_result = (result_q >> step_k) | (result_q << (WIDTH_AMT - step_k));
      OP_ROL:  step_result = (result_q << step_k) | (result_q >> (WIDTH_AMT - step_k));
`endif
      default: step_result = result_q;
    endcase
  end

  // Next-state logic: idle -> shift (or straight to done) on start, shift until rem drains, done lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (op_illegal || (eff_amt == '0)) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rem_q == step_k) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture the request on acceptance, then advance result and rem each shift cycle.
  always_comb begin
    op_d     = op_q;
    sign_d   = sign_q;
    ill_d    = ill_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (state_q == ST_IDLE && start) begin
      op_d     = op;
      sign_d   = operand[WIDTH-1];
      ill_d    = op_illegal;
      rem_d    = eff_amt;
      result_d = operand;
    end else if (state_q == ST_SHIFT) begin
      result_d = step_result;
      rem_d    = rem_q - step_k;
    end
  end

  // State and datapath registers; clear wins over everything, including a pending start.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      sign_q   <= 1'b0;
      ill_q    <= 1'b0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      ill_q    <= ill_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    illegal = (state_q == ST_DONE) && ill_q;
    result  = result_q;
  end

endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;

  localparam int WIDTH   = 32;
  localparam int STEP    = 4;
  localparam int SHAMT_W = 6;

  logic               clock = 1'b0;
  logic               clear;
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] amount;
  logic               busy;
  logic               done;
  logic               illegal;
  logic [WIDTH-1:0]   result;

  int errors = 0;
  int checks = 0;

  shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .op      (op),
    .operand (operand),
    .amount  (amount),
    .busy    (busy),
    .done    (done),
    .illegal (illegal),
    .result  (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the operation rules, using wide arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [5:0] a,
                                output logic [31:0] r, output logic ill, output int lat);
    int          eff;
    logic [63:0] w;
    longint      s;
    ill = 1'b0;
    eff = (int'(a) > WIDTH) ? WIDTH : int'(a);
    r   = x;
    case (o)
      3'd0: begin w = {32'b0, x} >> eff; r = w[31:0]; end
      3'd1: begin s = longint'($signed(x)); s = s >>> eff; r = s[31:0]; end
      3'd2: begin w = {32'b0, x} << eff; r = w[31:0]; end
`ifdef SHIFT_UNIT_ROTATE_EN
      3'd3: begin eff = int'(a) % WIDTH; w = {x, x} >> eff; r = w[31:0]; end
      3'd4: begin eff = int'(a) % WIDTH; w = {x, x} << eff; r = w[63:32]; end
`endif
      default: begin ill = 1'b1; eff = 0; r = x; end
    endcase
    lat = (eff + STEP - 1) / STEP + 1;
  endfunction

  // Inputs while busy: mode 0 quiet, 1 start stuck high, 2 random start; data always scrambled.
  task automatic busy_inputs(input int mode);
    start   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    op      = 3'($urandom_range(0, 7));
    operand = $urandom;
    amount  = 6'($urandom_range(0, 63));
  endtask

  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] x,
                       input logic [5:0] a, input int mode);
    logic [31:0] exp_r;
    logic        exp_ill;
    int          exp_lat;
    int          cyc;
    model(o, x, a, exp_r, exp_ill, exp_lat);
    @(negedge clock);
    start = 1'b1; op = o; operand = x; amount = a;
    @(posedge clock); #1;
    cyc = 1;
    busy_inputs(mode);
    while (!done && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      busy_inputs(mode);
    end
    check({name, ".latency"}, 32'(cyc), 32'(exp_lat));
    check({name, ".result"}, result, exp_r);
    check({name, ".illegal"}, 32'(illegal), 32'(exp_ill));
    check({name, ".busy_at_done"}, 32'(busy), 32'd1);
    @(posedge clock); #1;
    start = 1'b0;
    check({name, ".done_pulse"}, 32'(done), 32'd0);
    check({name, ".idle_after"}, 32'(busy), 32'd0);
    check({name, ".held"}, result, exp_r);
  endtask

  initial begin
    int n_done;
    // Reset with start held high: clear must take priority.
    clear = 1'b1; start = 1'b1; op = 3'd0; operand = 32'hDEADBEEF; amount = 6'd5;
    repeat (3) @(posedge clock);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.result", result, 32'd0);
    clear = 1'b0; start = 1'b0;
    @(posedge clock); #1;
    check("rst.still_idle", 32'(busy), 32'd0);

    // Directed cases.
    do_op("shra4", 3'd1, 32'h80000010, 6'd4, 0);
    check("shra4.const", result, 32'hF8000001);
    do_op("shr40", 3'd0, 32'hFFFFFFFF, 6'd40, 0);
    check("shr40.const", result, 32'h00000000);
    do_op("shra40", 3'd1, 32'hFFFFFFFF, 6'd40, 0);
    check("shra40.const", result, 32'hFFFFFFFF);
    do_op("shl0", 3'd2, 32'h00000001, 6'd0, 0);
    do_op("rol33", 3'd4, 32'h80000001, 6'd33, 0);
    do_op("ror63", 3'd3, 32'h12345678, 6'd63, 0);
    do_op("op7", 3'd7, 32'h00001234, 6'd9, 0);
    check("op7.const", result, 32'h00001234);
    do_op("op3", 3'd3, 32'h00001234, 6'd5, 0);
    do_op("shl32", 3'd2, 32'hA5A5A5A5, 6'd32, 0);

    // Start stuck high through shift and the done cycle must be ignored; next idle start is accepted.
    do_op("ignore", 3'd0, 32'hFFFFFFFF, 6'd31, 1);
    do_op("after_ignore", 3'd2, 32'h0000000F, 6'd7, 0);

    // Clear in the middle of a long shift.
    @(negedge clock);
    start = 1'b1; op = 3'd0; operand = 32'hFFFFFFFF; amount = 6'd31;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    clear = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0; start = 1'b0;
    check("clr.busy", 32'(busy), 32'd0);
    check("clr.done", 32'(done), 32'd0);
    check("clr.result", result, 32'd0);
    check("clr.illegal", 32'(illegal), 32'd0);
    n_done = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (done) n_done++;
    end
    check("clr.no_done", 32'(n_done), 32'd0);
    do_op("after_clr", 3'd0, 32'hFFFFFFFF, 6'd31, 0);

    // Random requests with random noise on the inputs while busy.
    for (int i = 0; i < 250; i++) begin
      do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), $urandom,
            6'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
